// File: rtl/noise_sched_pkg.sv
// noise_sched_pkg: shared state encoding and default widths for the noise anneal scheduler
package noise_sched_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;
  localparam int THR_W_DEF = 8;
  localparam int CNT_W_DEF = 16;
  localparam int THR_OFF = 0;
endpackage

// File: rtl/noise_anneal_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant with a registered rotating priority pointer
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               en_i,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o
);
  logic [PW-1:0] ptr_q, ptr_d, idx;
  logic hit;
  int j;
  always_comb begin
    gnt_o = '0;
    idx = '0;
    hit = 1'b0;
    j = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr_q) + k) % NUM_REQ;
      if (!hit && req_i[j]) begin
        hit = 1'b1;
        idx = PW'(j);
        gnt_o[j] = 1'b1;
      end
    end
    ptr_d = (en_i && hit) ? ((int'(idx) == NUM_REQ - 1) ? '0 : idx + PW'(1)) : ptr_q;
  end
  always_ff @(posedge clk or posedge rstb)
    if (rstb) ptr_q <= '0;
    else ptr_q <= ptr_d;
endmodule

// File: rtl/noise_anneal_sched.sv
// noise_anneal_sched: steps the noise threshold down a dwell-timed schedule and round-robins the noise word
import noise_sched_pkg::*;
module noise_anneal_sched #(
  parameter int NUM_REQ = 4,
  parameter int THR_W = THR_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic [THR_W-1:0]   cfg_start_thr,
  input  logic [THR_W-1:0]   cfg_end_thr,
  input  logic [THR_W-1:0]   cfg_step,
  input  logic [CNT_W-1:0]   cfg_dwell,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic [THR_W-1:0]   thr_out,
  input  logic [7:0]         noise_in,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [7:0]         noise_out,
  output logic               noise_valid
);
  state_e state_q, state_d;
  logic [THR_W-1:0] thr_q, thr_d, end_q, end_d, step_q, step_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_REQ-1:0] arb_gnt, gnt_q, gnt_d;
  logic [7:0] nout_q, nout_d;
  logic nv_q, en;
  logic [THR_W:0] diff;
  always_ff @(posedge clk or posedge rstb)
    if (rstb) begin
      state_q <= IDLE;
      thr_q <= THR_W'(THR_OFF);
      end_q <= '0;
      step_q <= '0;
      cnt_q <= '0;
      gnt_q <= '0;
      nout_q <= '0;
      nv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      thr_q <= thr_d;
      end_q <= end_d;
      step_q <= step_d;
      cnt_q <= cnt_d;
      gnt_q <= gnt_d;
      nout_q <= nout_d;
      nv_q <= |gnt_d;
    end
  // the extra MSB keeps thr-step from wrapping below zero before the clamp to end
  always_comb begin
    state_d = state_q;
    thr_d = thr_q;
    cnt_d = cnt_q;
    end_d = end_q;
    step_d = step_q;
    diff = {1'b0, thr_q} - {1'b0, step_q};
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        thr_d = cfg_start_thr;
        cnt_d = cfg_dwell;
        end_d = cfg_end_thr;
        step_d = (cfg_step == '0) ? THR_W'(1) : cfg_step;
      end
      RUN: if (abort) begin
        state_d = IDLE;
        thr_d = THR_W'(THR_OFF);
      end else if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      else if (thr_q <= end_q) begin
        state_d = FIN;
        thr_d = THR_W'(THR_OFF);
      end else begin
        thr_d = (diff[THR_W] || diff[THR_W-1:0] < end_q) ? end_q : diff[THR_W-1:0];
        cnt_d = cfg_dwell;
      end
      default: begin
        state_d = IDLE;
        thr_d = THR_W'(THR_OFF);
      end
    endcase
  end
  // grants only issue when the schedule stays in RUN across the edge
  always_comb begin
    en = (state_q == RUN) && (state_d == RUN);
    gnt_d = en ? arb_gnt : '0;
    nout_d = (|gnt_d) ? noise_in : 8'd0;
    busy = state_q == RUN;
    done = state_q == FIN;
  end
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk(clk),
    .rstb(rstb),
    .en_i(en),
    .req_i(req),
    .gnt_o(arb_gnt)
  );
  assign thr_out = thr_q;
  assign gnt = gnt_q;
  assign noise_out = nout_q;
  assign noise_valid = nv_q;
endmodule

// File: tb/tb_noise_anneal_sched.sv
// tb_noise_anneal_sched: randomized checks of the anneal schedule and noise arbitration against a level-list model
module tb_noise_anneal_sched;
  localparam int N = 4;
  logic clk = 1'b0, rstb = 1'b0;
  logic [7:0] cfg_start_thr, cfg_end_thr, cfg_step, noise_in;
  logic [15:0] cfg_dwell;
  logic start, abort, busy, done, noise_valid;
  logic [N-1:0] req, gnt, eg;
  logic [7:0] thr_out, noise_out, eno;
  int n_tests = 0, n_fail = 0, mptr = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  noise_anneal_sched #(.NUM_REQ(N), .THR_W(8), .CNT_W(16)) dut (
    .clk(clk), .rstb(rstb), .cfg_start_thr(cfg_start_thr), .cfg_end_thr(cfg_end_thr),
    .cfg_step(cfg_step), .cfg_dwell(cfg_dwell), .start(start), .abort(abort),
    .busy(busy), .done(done), .thr_out(thr_out), .noise_in(noise_in), .req(req),
    .gnt(gnt), .noise_out(noise_out), .noise_valid(noise_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // list of threshold values, one entry per RUN cycle
  function automatic void build(input int s, input int e, input int st, input int d);
    int lvl, stp;
    exp_q.delete();
    lvl = s;
    stp = (st == 0) ? 1 : st;
    forever begin
      repeat (d + 1) exp_q.push_back(lvl);
      if (lvl <= e) break;
      lvl = (lvl - stp < e) ? e : lvl - stp;
    end
  endfunction

  function automatic logic [N-1:0] rr(input logic [N-1:0] r);
    logic [N-1:0] g = '0;
    for (int k = 0; k < N; k++)
      if (g == '0 && r[(mptr + k) % N]) begin
        g[(mptr + k) % N] = 1'b1;
        mptr = (mptr + k + 1) % N;
      end
    return g;
  endfunction

  task automatic test_reset();
    start = 1'b1;
    abort = 1'b0;
    req = '1;
    noise_in = 8'hA5;
    cfg_start_thr = 8'd40; cfg_end_thr = 8'd10; cfg_step = 8'd10; cfg_dwell = 16'd2;
    #1 rstb = 1'b1;
    tick(); tick();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_tests++; if (thr_out !== 8'd0) begin n_fail++; $display("FAIL reset_thr got %0d want 0", thr_out); end
    n_tests++; if (gnt !== '0) begin n_fail++; $display("FAIL reset_gnt got %b want 0", gnt); end
    n_tests++; if (noise_out !== 8'd0) begin n_fail++; $display("FAIL reset_nout got %0d want 0", noise_out); end
    n_tests++; if (noise_valid !== 1'b0) begin n_fail++; $display("FAIL reset_nv got %b want 0", noise_valid); end
    start = 1'b0;
    req = '0;
    rstb = 1'b0;
    mptr = 0;
    tick();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy got %b want 0", busy); end
  endtask

  task automatic test_arbiter();
    logic [N-1:0] r;
    cfg_start_thr = 8'd50; cfg_end_thr = 8'd60; cfg_step = 8'd1; cfg_dwell = 16'd39;
    start = 1'b1; tick(); start = 1'b0;
    eg = '0; eno = 8'd0;
    for (int c = 0; c < 40; c++) begin
      n_tests++; if (gnt !== eg) begin n_fail++; $display("FAIL arb_gnt c=%0d got %b want %b", c, gnt, eg); end
      n_tests++; if (noise_out !== eno) begin n_fail++; $display("FAIL arb_nout c=%0d got %0d want %0d", c, noise_out, eno); end
      n_tests++; if (noise_valid !== (|eg)) begin n_fail++; $display("FAIL arb_nv c=%0d got %b want %b", c, noise_valid, |eg); end
      n_tests++; if (thr_out !== 8'd50 || busy !== 1'b1) begin n_fail++; $display("FAIL arb_thr c=%0d got %0d/%b want 50/1", c, thr_out, busy); end
      r = (c < 12) ? 4'b1011 : (c < 32) ? N'($urandom) : '0;
      req = r;
      noise_in = (c < 12) ? 8'(c + 1) : 8'($urandom);
      if (c < 39 && r != '0) begin eg = rr(r); eno = noise_in; end
      else begin eg = '0; eno = 8'd0; end
      tick();
    end
    req = '0;
    n_tests++; if (done !== 1'b1 || gnt !== '0 || noise_valid !== 1'b0 || thr_out !== 8'd0)
      begin n_fail++; $display("FAIL arb_fin got done=%b gnt=%b nv=%b thr=%0d want 1/0/0/0", done, gnt, noise_valid, thr_out); end
    tick();
    n_tests++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL arb_idle got done=%b busy=%b want 0/0", done, busy); end
  endtask

  task automatic test_schedules();
    int s, e, st, d;
    int tbl [4][4] = '{'{40, 10, 10, 2}, '{40, 15, 10, 0}, '{5, 20, 10, 1}, '{3, 1, 0, 0}};
    for (int t = 0; t < 9; t++) begin
      if (t < 4) begin s = tbl[t][0]; e = tbl[t][1]; st = tbl[t][2]; d = tbl[t][3]; end
      else begin s = $urandom_range(0, 255); e = $urandom_range(0, 255); st = $urandom_range(0, 40); d = $urandom_range(0, 3); end
      build(s, e, st, d);
      cfg_start_thr = 8'(s); cfg_end_thr = 8'(e); cfg_step = 8'(st); cfg_dwell = 16'(d);
      start = 1'b1; tick(); start = 1'b0;
      cfg_start_thr = 8'($urandom); cfg_end_thr = 8'($urandom); cfg_step = 8'($urandom);
      foreach (exp_q[i]) begin
        n_tests++;
        if (thr_out !== 8'(exp_q[i]) || busy !== 1'b1 || done !== 1'b0 || gnt !== '0) begin
          n_fail++;
          $display("FAIL sched t=%0d i=%0d got thr=%0d busy=%b done=%b gnt=%b want thr=%0d 1/0/0", t, i, thr_out, busy, done, gnt, exp_q[i]);
        end
        tick();
      end
      n_tests++; if (done !== 1'b1 || busy !== 1'b0 || thr_out !== 8'd0)
        begin n_fail++; $display("FAIL sched_fin t=%0d got done=%b busy=%b thr=%0d want 1/0/0", t, done, busy, thr_out); end
      tick();
      n_tests++; if (done !== 1'b0 || busy !== 1'b0)
        begin n_fail++; $display("FAIL sched_done_width t=%0d got done=%b busy=%b want 0/0", t, done, busy); end
    end
  endtask

  task automatic test_abort();
    build(40, 10, 10, 2);
    cfg_start_thr = 8'd40; cfg_end_thr = 8'd10; cfg_step = 8'd10; cfg_dwell = 16'd2;
    req = 4'b1111;
    start = 1'b1; tick(); start = 1'b0;
    eg = '0;
    for (int c = 0; c < 4; c++) begin
      n_tests++; if (thr_out !== 8'(exp_q[c]) || gnt !== eg || done !== 1'b0)
        begin n_fail++; $display("FAIL abort_run c=%0d got thr=%0d gnt=%b done=%b want %0d/%b/0", c, thr_out, gnt, done, exp_q[c], eg); end
      noise_in = 8'($urandom);
      abort = (c == 3);
      eg = (c < 3) ? rr(req) : '0;
      tick();
    end
    abort = 1'b0;
    n_tests++; if (thr_out !== 8'd0 || busy !== 1'b0 || gnt !== '0 || noise_valid !== 1'b0 || done !== 1'b0)
      begin n_fail++; $display("FAIL abort_idle got thr=%0d busy=%b gnt=%b nv=%b done=%b want all 0", thr_out, busy, gnt, noise_valid, done); end
    start = 1'b1; tick(); start = 1'b0;
    n_tests++; if (busy !== 1'b1 || thr_out !== 8'd40 || gnt !== '0)
      begin n_fail++; $display("FAIL abort_restart got busy=%b thr=%0d gnt=%b want 1/40/0", busy, thr_out, gnt); end
    abort = 1'b1; tick(); abort = 1'b0;
    req = '0;
    for (int c = 0; c < 3; c++) begin
      n_tests++; if (busy !== 1'b0 || done !== 1'b0)
        begin n_fail++; $display("FAIL abort_nodone c=%0d got busy=%b done=%b want 0/0", c, busy, done); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int last;
    build(40, 10, 10, 2);
    last = exp_q.size() - 1;
    cfg_start_thr = 8'd40; cfg_end_thr = 8'd10; cfg_step = 8'd10; cfg_dwell = 16'd2;
    start = 1'b1; tick(); start = 1'b0;
    cfg_start_thr = 8'd99;
    foreach (exp_q[i]) begin
      n_tests++; if (thr_out !== 8'(exp_q[i]) || busy !== 1'b1)
        begin n_fail++; $display("FAIL b2b_ignore i=%0d got thr=%0d busy=%b want %0d/1", i, thr_out, busy, exp_q[i]); end
      start = (i == 2 || i == 5);
      if (i == last) start = 1'b0;
      tick();
    end
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_fin got done=%b want 1", done); end
    cfg_start_thr = 8'd77;
    start = 1'b1; tick();
    n_tests++; if (busy !== 1'b0 || done !== 1'b0 || thr_out !== 8'd0)
      begin n_fail++; $display("FAIL b2b_idle got busy=%b done=%b thr=%0d want 0/0/0", busy, done, thr_out); end
    tick(); start = 1'b0;
    n_tests++; if (busy !== 1'b1 || thr_out !== 8'd77)
      begin n_fail++; $display("FAIL b2b_restart got busy=%b thr=%0d want 1/77", busy, thr_out); end
    abort = 1'b1; tick(); abort = 1'b0;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_abort got busy=%b want 0", busy); end
  endtask

  task automatic test_async_reset();
    cfg_start_thr = 8'd40; cfg_end_thr = 8'd10; cfg_step = 8'd10; cfg_dwell = 16'd3;
    req = 4'b0100;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    n_tests++; if (gnt !== 4'b0100 || busy !== 1'b1)
      begin n_fail++; $display("FAIL arst_pre got gnt=%b busy=%b want 0100/1", gnt, busy); end
    #3 rstb = 1'b1;
    #1;
    n_tests++; if (busy !== 1'b0 || done !== 1'b0 || thr_out !== 8'd0 || gnt !== '0 || noise_out !== 8'd0 || noise_valid !== 1'b0)
      begin n_fail++; $display("FAIL arst_async got busy=%b done=%b thr=%0d gnt=%b nout=%0d nv=%b want all 0", busy, done, thr_out, gnt, noise_out, noise_valid); end
    #1 rstb = 1'b0;
    mptr = 0;
    req = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_tests++; if (busy !== 1'b0 || done !== 1'b0)
        begin n_fail++; $display("FAIL arst_nodone c=%0d got busy=%b done=%b want 0/0", c, busy, done); end
    end
  endtask

  initial begin
    test_reset();
    test_arbiter();
    test_schedules();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/noise_anneal_sched.md
Name: noise_anneal_sched

Overview:
- Sequences an annealing schedule for the shared noise source that feeds soft-associative-memory recall.
- Drives the noise generator's threshold (injection frequency) from a start value down to an end value in fixed steps, holding each level for a programmable dwell.
- Arbitrates the single 8-bit noise word among NUM_REQ recall banks with round-robin grants.
- Sits between the recall controller (start/abort/done) and the noise generator plus memory banks.

Parameters:
NUM_REQ, 4, number of noise requesters (banks)
THR_W, 8, threshold width; matches the noise generator compare width
CNT_W, 16, dwell counter width

Ports:
clk  in  1  clock; all state updates on posedge
rstb  in  1  reset, asynchronous, active-high (asserted = 1)
cfg_start_thr  in  THR_W  initial threshold
cfg_end_thr  in  THR_W  final threshold
cfg_step  in  THR_W  decrement per level
cfg_dwell  in  CNT_W  cycles per level minus 1
start  in  1  begin schedule; sampled in IDLE only
abort  in  1  terminate schedule
busy  out  1  high in RUN
done  out  1  one-cycle pulse at normal completion
thr_out  out  THR_W  threshold to noise generator; 0 means no noise
noise_in  in  8  noise word from generator
req  in  NUM_REQ  per-bank noise request
gnt  out  NUM_REQ  one-hot grant, registered
noise_out  out  8  noise word for granted bank
noise_valid  out  1  high when gnt nonzero

Behaviour:
- Reset (rstb=1, async): state=IDLE; busy=0, done=0, thr_out=0, gnt=0, noise_out=0, noise_valid=0, RR pointer=0, dwell_cnt=0.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - start=1 latches end/step into shadow registers (cfg_* may change afterwards).
  - Next cycle: RUN, thr_out=cfg_start_thr, dwell_cnt=cfg_dwell, busy=1.
- RUN, per cycle:
  - abort=1: next IDLE, thr_out=0, busy=0, no done pulse. Abort has priority over dwell expiry.
  - Else dwell_cnt!=0: decrement.
  - Else if thr_out<=end_shadow: next FIN.
  - Else thr_out = max(thr_out-step, end_shadow), computed in THR_W+1 bits (no wrap); dwell_cnt reloads.
  - step=0 is treated as step=1.
- Level timing: each level holds exactly cfg_dwell+1 cycles. cfg_dwell=0 gives 1 cycle per level.
- Degenerate schedule: start_thr<=end_thr gives one level at start_thr, then FIN.
- FIN: done=1 for exactly one cycle, thr_out=0, busy=0; next IDLE.
- start while RUN/FIN is ignored. A start in the first IDLE cycle after FIN is accepted.
- Arbitration, RUN only:
  - Each cycle grant the first asserted req at or after the RR pointer (wrapping).
  - gnt registered (appears 1 cycle after req sampled); noise_out<=noise_in in the same edge; noise_valid<=|gnt.
  - Pointer advances to granted index+1 mod NUM_REQ. No req: gnt=0, noise_out=0, pointer unchanged.
  - Outside RUN (incl. the abort cycle's next state): gnt=0, noise_out=0, noise_valid=0.
- Reset mid-RUN returns everything to reset values immediately; no done pulse.

Decomposition:
- Package noise_sched_pkg:
  - state enum (IDLE/RUN/FIN)
  - THR_W/CNT_W defaults
  - THR_OFF=0 constant
- Sub-module rr_arbiter (NUM_REQ, combinational grant + registered pointer), instantiated once.
- Schedule FSM/counters in top.

Test Plan:
- start_thr=40, end=10, step=10, dwell=2, no abort -> thr_out 40,40,40,30,30,30,20,20,20,10,10,10 then done pulse 1 cycle, thr_out=0, busy falls with done.
- start=40, end=15, step=10, dwell=0 -> thr_out 40,30,20,15 (saturates at end, no wrap), then done.
- start=5, end=20, dwell=1 -> thr_out 5 for 2 cycles, then done; step=0 run with start=3, end=1 -> 3,2,1.
- abort asserted on 4th RUN cycle of scenario 1 -> next cycle thr_out=0, busy=0, gnt=0, done never asserts; immediate restart accepted.
- RUN with req=4'b1011 constant, noise_in incrementing -> gnt cycles 0001,0010,1000,0001...; noise_out equals noise_in of previous cycle; noise_valid=1 throughout; req=0 -> gnt=0, noise_valid=0.
- rstb pulsed asynchronously mid-level -> all outputs zero without clock edge; start pulse while busy has no effect on thr_out sequence.
